// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART: register map, CTRL layout, STATUS bits,
// FSM states and parity helpers.
package uart_apb_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_BAUD   = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd5;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_BUSY  = 4;
    localparam int unsigned ST_PAR_ERR  = 5;
    localparam int unsigned ST_FRM_ERR  = 6;
    localparam int unsigned ST_OVERRUN  = 7;

    localparam int unsigned BAUD_RESET = 10417;
    localparam int unsigned BAUD_MIN   = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    // CTRL register layout, MSB first
    typedef struct packed {
        logic    loopback;
        logic    stop2;
        parity_e parity;
        logic    rx_clr;
        logic    tx_clr;
        logic    rx_en;
        logic    tx_en;
    } ctrl_t;

    function automatic logic parity_on(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with synchronous clear; push and pop may coincide.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB-attached UART with TX/RX byte FIFOs, optional parity, 1/2 stop bits,
// sticky error flags and a level interrupt.
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 20,
    parameter int unsigned APB_WIDTH  = 32
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [APB_WIDTH-1:0] PADDR,
    input  logic [APB_WIDTH-1:0] PWDATA,
    output logic [APB_WIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 tx,
    input  logic                 rx,
    output logic                 irq
);
    ctrl_t                ctrl;
    logic [DIV_WIDTH-1:0] baud;
    logic [2:0]           irq_en;
    logic                 par_err, frm_err, overrun;
    logic [7:0]           status;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       access, wr_c, st_w1c_c;
    logic [2:0] addr;
    logic       tx_push_c, tx_pop_c, rx_push_c, rx_pop_c, tx_clr_c, rx_clr_c;
    logic       rx_perr_c, rx_ferr_c;
    logic       unused_bits;

    assign access      = PSEL & PENABLE;
    assign addr        = PADDR[4:2];
    assign wr_c        = access & PWRITE;
    assign st_w1c_c    = wr_c & (addr == ADDR_STATUS);
    assign tx_clr_c    = wr_c & (addr == ADDR_CTRL) & PWDATA[2];
    assign rx_clr_c    = wr_c & (addr == ADDR_CTRL) & PWDATA[3];
    assign PREADY      = 1'b1;
    assign unused_bits = ^{PADDR[APB_WIDTH-1:5], PADDR[1:0], PWDATA[APB_WIDTH-1:DIV_WIDTH]};

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .clr(tx_clr_c), .push(tx_push_c), .pop(tx_pop_c),
        .wdata(PWDATA[7:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    // ---------------- TX FSM ----------------
    uart_state_e          tx_state, tx_state_n;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [7:0]           tx_byte, tx_byte_n;
    logic                 tx_stop2, tx_stop2_n, tx_n, tx_end;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_stop2 <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            tx_stop2 <= tx_stop2_n;
            tx       <= tx_n;
        end
    end

    // Bit timer reloads from the live BAUD at every boundary
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt - DIV_WIDTH'(1);
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_stop2_n = tx_stop2;
        tx_n       = tx;
        tx_pop_c   = 1'b0;
        tx_end     = (tx_cnt == '0);
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = baud - DIV_WIDTH'(1);
                tx_n     = 1'b1;
                if (ctrl.tx_en && !tx_empty) begin
                    tx_pop_c   = 1'b1;
                    tx_byte_n  = tx_head;
                    tx_state_n = S_START;
                    tx_n       = 1'b0;
                end
            end
            S_START: if (tx_end) begin
                tx_state_n = S_DATA;
                tx_cnt_n   = baud - DIV_WIDTH'(1);
                tx_bit_n   = '0;
                tx_n       = tx_byte[0];
            end
            S_DATA: if (tx_end) begin
                tx_cnt_n = baud - DIV_WIDTH'(1);
                if (tx_bit == 3'd7) begin
                    if (parity_on(ctrl.parity)) begin
                        tx_state_n = S_PARITY;
                        tx_n       = parity_bit(tx_byte, ctrl.parity);
                    end else begin
                        tx_state_n = S_STOP;
                        tx_n       = 1'b1;
                        tx_stop2_n = ctrl.stop2;
                    end
                end else begin
                    tx_bit_n = tx_bit + 3'd1;
                    tx_n     = tx_byte[tx_bit_n];
                end
            end
            S_PARITY: if (tx_end) begin
                tx_state_n = S_STOP;
                tx_cnt_n   = baud - DIV_WIDTH'(1);
                tx_n       = 1'b1;
                tx_stop2_n = ctrl.stop2;
            end
            S_STOP: if (tx_end) begin
                tx_cnt_n = baud - DIV_WIDTH'(1);
                if (tx_stop2) tx_stop2_n = 1'b0;
                else          tx_state_n = S_IDLE;
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // ---------------- RX FSM ----------------
    uart_state_e          rx_state, rx_state_n;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [7:0]           rx_shift, rx_shift_n;
    logic                 rx_perr, rx_perr_n, rx_end;
    logic                 rx_s1, rx_s2, rx_prev;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_s1    <= ctrl.loopback ? tx : rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_perr  <= rx_perr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt - DIV_WIDTH'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_perr_n  = rx_perr;
        rx_push_c  = 1'b0;
        rx_perr_c  = 1'b0;
        rx_ferr_c  = 1'b0;
        rx_end     = (rx_cnt == '0);
        if (!ctrl.rx_en) begin
            rx_state_n = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt_n  = (baud >> 1) - DIV_WIDTH'(1);
                    rx_perr_n = 1'b0;
                    if (rx_prev && !rx_s2) rx_state_n = S_START;
                end
                S_START: if (rx_end) begin
                    rx_cnt_n   = baud - DIV_WIDTH'(1);
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_end) begin
                    rx_cnt_n   = baud - DIV_WIDTH'(1);
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_n = parity_on(ctrl.parity) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_end) begin
                    rx_cnt_n   = baud - DIV_WIDTH'(1);
                    rx_perr_n  = (rx_s2 != parity_bit(rx_shift, ctrl.parity));
                    rx_state_n = S_STOP;
                end
                S_STOP: if (rx_end) begin
                    rx_push_c  = 1'b1;
                    rx_perr_c  = rx_perr;
                    rx_ferr_c  = ~rx_s2;
                    rx_state_n = S_IDLE;
                end
                default: rx_state_n = S_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .clr(rx_clr_c), .push(rx_push_c), .pop(rx_pop_c),
        .wdata(rx_shift), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- APB registers ----------------
    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_BUSY]  = (tx_state != S_IDLE);
        status[ST_PAR_ERR]  = par_err;
        status[ST_FRM_ERR]  = frm_err;
        status[ST_OVERRUN]  = overrun;
    end

    always_comb begin
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        tx_push_c = 1'b0;
        rx_pop_c  = 1'b0;
        if (access) begin
            case (addr)
                ADDR_CTRL:   if (!PWRITE) PRDATA = APB_WIDTH'(ctrl);
                ADDR_BAUD:   if (!PWRITE) PRDATA = APB_WIDTH'(baud);
                ADDR_TXDATA: if (PWRITE) begin
                    tx_push_c = 1'b1;
                    PSLVERR   = tx_full & ~tx_pop_c;
                end
                ADDR_RXDATA: if (!PWRITE) begin
                    if (rx_empty) begin
                        PSLVERR = 1'b1;
                    end else begin
                        PRDATA   = APB_WIDTH'(rx_head);
                        rx_pop_c = 1'b1;
                    end
                end
                ADDR_STATUS: if (!PWRITE) PRDATA = APB_WIDTH'(status);
                ADDR_IRQ_EN: if (!PWRITE) PRDATA = APB_WIDTH'(irq_en);
                default:     PSLVERR = 1'b1;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ctrl    <= '0;
            baud    <= DIV_WIDTH'(BAUD_RESET);
            irq_en  <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_c && addr == ADDR_CTRL)
                ctrl <= ctrl_t'({PWDATA[7:4], 2'b00, PWDATA[1:0]});
            if (wr_c && addr == ADDR_BAUD)
                baud <= (PWDATA[DIV_WIDTH-1:0] < DIV_WIDTH'(BAUD_MIN)) ?
                        DIV_WIDTH'(BAUD_MIN) : PWDATA[DIV_WIDTH-1:0];
            if (wr_c && addr == ADDR_IRQ_EN)
                irq_en <= PWDATA[2:0];
            // New error events win over a same-cycle write-1-to-clear
            par_err <= rx_perr_c | (par_err & ~(st_w1c_c & PWDATA[ST_PAR_ERR]));
            frm_err <= rx_ferr_c | (frm_err & ~(st_w1c_c & PWDATA[ST_FRM_ERR]));
            overrun <= (rx_push_c & rx_full & ~rx_pop_c) |
                       (overrun & ~(st_w1c_c & PWDATA[ST_OVERRUN]));
            irq     <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) |
                       (irq_en[2] & (par_err | frm_err | overrun));
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: register access, loopback frames, parity,
// framing, FIFO full/overrun and mid-frame reset.
module tb_uart_apb_fifo;

    localparam int unsigned BAUD = 10;
    localparam logic [31:0] A_CTRL = 32'h00, A_BAUD = 32'h04, A_TX = 32'h08,
                            A_RX = 32'h0C, A_ST = 32'h10, A_IE = 32'h14, A_BAD = 32'h18;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        tx, irq;
    logic        rx = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int frames  = 0;

    uart_apb_fifo dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Counts frame starts on tx; skips the body of each frame
    always begin
        @(negedge tx);
        frames = frames + 1;
        repeat (95) @(posedge PCLK);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #3 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #3 begin data = PRDATA; err = PSLVERR; end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BAUD) @(posedge PCLK);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] data, input logic has_par, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (has_par) drive_bit(par);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic wait_tx_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge PCLK); #1;
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    logic [31:0] rd;
    logic        er, ok, any_err;
    logic [10:0] frame;
    int          f0;

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Reset state
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_irq", 32'(irq), 32'd0);
        check_eq("idle_prdata", PRDATA, 32'd0);
        check_eq("idle_pslverr", 32'(PSLVERR), 32'd0);
        check_eq("pready", 32'(PREADY), 32'd1);
        apb_read(A_ST, rd, er);
        check_eq("reset_status", rd, 32'h0A);
        apb_read(A_BAUD, rd, er);
        check_eq("reset_baud", rd, 32'd10417);
        apb_read(A_CTRL, rd, er);
        check_eq("reset_ctrl", rd, 32'd0);
        apb_read(A_BAD, rd, er);
        check_eq("bad_addr_data", rd, 32'd0);
        check_eq("bad_addr_err", 32'(er), 32'd1);

        // BAUD clamp
        apb_write(A_BAUD, 32'd2, er);
        apb_read(A_BAUD, rd, er);
        check_eq("baud_clamp", rd, 32'd4);
        apb_write(A_BAUD, BAUD, er);

        // tx_empty interrupt
        apb_write(A_IE, 32'h2, er);
        wait_cycles(2);
        check_eq("irq_tx_empty", 32'(irq), 32'd1);
        apb_write(A_IE, 32'h0, er);
        wait_cycles(2);
        check_eq("irq_off", 32'(irq), 32'd0);

        // Loopback, no parity
        apb_write(A_CTRL, 32'h83, er);
        apb_write(A_TX, 32'hA1, er);
        check_eq("tx_push_err", 32'(er), 32'd0);
        wait_cycles(150);
        apb_read(A_ST, rd, er);
        check_eq("lb_rx_empty", 32'(rd[3]), 32'd0);
        apb_read(A_RX, rd, er);
        check_eq("lb_rx_data", rd, 32'hA1);
        check_eq("lb_rx_err", 32'(er), 32'd0);

        // Odd parity loopback: frame start,data LSB first,parity,stop
        apb_write(A_CTRL, 32'hA3, er);
        apb_write(A_TX, 32'h3C, er);
        wait_tx_low(ok);
        check_eq("par_tx_start_seen", 32'(ok), 32'd1);
        repeat (5) @(posedge PCLK);
        #1 frame[0] = tx;
        for (int k = 1; k < 11; k++) begin
            repeat (BAUD) @(posedge PCLK);
            #1 frame[k] = tx;
        end
        check_eq("par_tx_frame", 32'(frame), 32'h678);
        wait_cycles(30);
        apb_read(A_RX, rd, er);
        check_eq("par_rx_data", rd, 32'h3C);
        apb_read(A_ST, rd, er);
        check_eq("par_no_err", 32'(rd[5]), 32'd0);

        // Inject even-parity frame while odd parity configured
        apb_write(A_CTRL, 32'h22, er);
        apb_write(A_IE, 32'h4, er);
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        apb_read(A_ST, rd, er);
        check_eq("par_err_set", 32'(rd[5]), 32'd1);
        check_eq("irq_err", 32'(irq), 32'd1);
        apb_write(A_ST, 32'h20, er);
        wait_cycles(2);
        apb_read(A_ST, rd, er);
        check_eq("par_err_w1c", 32'(rd[5]), 32'd0);
        check_eq("irq_err_clr", 32'(irq), 32'd0);
        apb_read(A_RX, rd, er);
        check_eq("par_err_byte_kept", rd, 32'h3C);

        // Framing error: stop bit low
        apb_write(A_CTRL, 32'h02, er);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        apb_read(A_ST, rd, er);
        check_eq("frm_err_set", 32'(rd[6]), 32'd1);
        apb_write(A_ST, 32'h40, er);
        apb_read(A_ST, rd, er);
        check_eq("frm_err_w1c", 32'(rd[6]), 32'd0);
        apb_read(A_RX, rd, er);
        check_eq("frm_err_byte_kept", rd, 32'h5A);

        // TX FIFO full with transmitter disabled
        apb_write(A_CTRL, 32'h82, er);
        any_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apb_write(A_TX, 32'(pat(i)), er);
            any_err = any_err | er;
        end
        check_eq("fill_no_err", 32'(any_err), 32'd0);
        apb_write(A_TX, 32'hFF, er);
        check_eq("tx_full_err", 32'(er), 32'd1);
        apb_read(A_ST, rd, er);
        check_eq("tx_full_flag", 32'(rd[0]), 32'd1);
        f0 = frames;
        apb_write(A_CTRL, 32'h83, er);
        wait_cycles(1800);
        check_eq("frame_count", 32'(frames - f0), 32'd16);
        apb_read(A_ST, rd, er);
        check_eq("rx_full_flag", 32'(rd[2]), 32'd1);
        check_eq("no_overrun_yet", 32'(rd[7]), 32'd0);

        // 17th received byte overruns
        apb_write(A_TX, 32'hEE, er);
        wait_cycles(150);
        apb_read(A_ST, rd, er);
        check_eq("overrun_set", 32'(rd[7]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            apb_read(A_RX, rd, er);
            check_eq($sformatf("rx_byte_%0d", i), rd, 32'(pat(i)));
        end
        apb_read(A_RX, rd, er);
        check_eq("rx_empty_data", rd, 32'd0);
        check_eq("rx_empty_err", 32'(er), 32'd1);

        // Reset in the middle of the data bits
        apb_write(A_CTRL, 32'h01, er);
        apb_write(A_TX, 32'h00, er);
        wait_tx_low(ok);
        check_eq("rst_tx_start_seen", 32'(ok), 32'd1);
        wait_cycles(24);
        check_eq("mid_data_tx_low", 32'(tx), 32'd0);
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check_eq("rst_tx_high", 32'(tx), 32'd1);
        PRESETn = 1'b1;
        apb_read(A_ST, rd, er);
        check_eq("rst_status", rd, 32'h0A);
        apb_read(A_BAUD, rd, er);
        check_eq("rst_baud", rd, 32'd10417);
        apb_read(A_CTRL, rd, er);
        check_eq("rst_ctrl", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_apb_fifo.md
UART_APB_FIFO -- requirements
Module: uart_apb_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO (power of two, 2..256).
REQ-002 SHALL have parameter DIV_WIDTH, default 20, meaning width of the baud divider (PCLK cycles per bit).
REQ-003 SHALL have parameter APB_WIDTH, default 32, meaning PADDR/PWDATA/PRDATA width.
REQ-004 SHALL have one clock; reset is synchronous and active-low: PCLK and PRESETn.
REQ-005 SHALL have port PCLK  input  1  system clock.
REQ-006 SHALL have port PRESETn  input  1  synchronous active-low reset.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB controls.
REQ-008 SHALL have ports PADDR, PWDATA  input  APB_WIDTH  APB address and write data.
REQ-009 SHALL have port PRDATA  output  APB_WIDTH  read data; 0 outside a read access phase.
REQ-010 SHALL have ports PREADY, PSLVERR  output  1  ready (constant 1, zero wait) and error.
REQ-011 SHALL have ports tx  output  1  serial out (idle 1); rx  input  1  serial in; irq  output  1  level interrupt.

Function
REQ-012 SHALL act on a register access only in the access phase (PSEL & PENABLE); one action per access.
REQ-013 SHALL decode PADDR[4:2]: 0 CTRL, 1 BAUD, 2 TXDATA (W), 3 RXDATA (R), 4 STATUS, 5 IRQ_EN; other addresses read 0, ignore writes, assert PSLVERR.
REQ-014 CTRL SHALL hold: [0] tx_en, [1] rx_en, [2] tx_clr, [3] rx_clr (self-clearing, read 0), [5:4] parity (00 none, 01 even, 10 odd, 11 treated as none), [6] two stop bits, [7] loopback (rx path fed from tx).
REQ-015 BAUD SHALL store PWDATA[DIV_WIDTH-1:0], clamping values below 4 to 4; one bit lasts BAUD PCLK cycles.
REQ-016 TXDATA write SHALL push PWDATA[7:0] if TX FIFO not full; if full, data is dropped and PSLVERR=1 for that access.
REQ-017 RXDATA read SHALL return {24'b0, head byte} and pop; if empty, PRDATA=0, no pop, PSLVERR=1.
REQ-018 STATUS SHALL hold: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] parity_err, [6] frame_err, [7] overrun; bits 5-7 sticky, cleared by writing 1.
REQ-019 irq SHALL equal OR of IRQ_EN[0]&~rx_empty, IRQ_EN[1]&tx_empty, IRQ_EN[2]&(parity_err|frame_err|overrun).
REQ-020 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; leaves IDLE when tx_en & ~tx_empty, popping one byte; each state lasts BAUD cycles; DATA sends 8 bits LSB first; PARITY skipped when parity none; STOP lasts 1 or 2 bit times; then back to IDLE.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; rx passes a 2-flop synchroniser; falling edge in IDLE with rx_en enters START; sample at BAUD/2, abort to IDLE if high; then sample every BAUD cycles.
REQ-022 RX SHALL set parity_err on mismatch and frame_err if first stop sample is 0; byte still pushed; exactly one stop bit checked.
REQ-023 RX push with RX FIFO full SHALL drop the byte and set overrun.
REQ-024 Simultaneous push and pop on one FIFO SHALL both occur, count unchanged; pop on full and push on empty behave normally.
REQ-025 tx_clr/rx_clr SHALL empty the FIFO in one cycle; a frame in progress completes.
REQ-026 Clearing tx_en mid-frame SHALL finish the current frame, then hold IDLE; clearing rx_en SHALL return RX to IDLE immediately, discarding partial data.
REQ-027 BAUD write mid-frame SHALL take effect at the next bit boundary.

Reset
REQ-028 On PRESETn=0 at a PCLK rising edge: CTRL=0, BAUD=10417, IRQ_EN=0, FIFOs empty, sticky flags 0, both FSMs IDLE, tx=1, irq=0, PRDATA=0, PSLVERR=0.
REQ-029 Reset mid-frame SHALL abort immediately with tx=1 on the following cycle.

Structure
REQ-030 Register offsets, CTRL/STATUS bit indices, FSM state enums and parity encodings SHALL live in shared package uart_apb_pkg.
REQ-031 The FIFO SHALL be sub-module uart_sync_fifo (parameter DEPTH, 8-bit data), instantiated twice.

Verification
REQ-032 BAUD=10, CTRL=0x83 (loopback), write TXDATA 0xA1 -> after 10 bit times + margin, rx_empty=0, RXDATA read 0xA1, PSLVERR=0.
REQ-033 Parity odd, BAUD=10, loopback, send 0x3C -> tx frame 0,00111100,1,1 (time-ordered, LSB first); received 0x3C, parity_err=0; inject even-parity frame on rx -> parity_err=1, W1C 0x20 clears it.
REQ-034 tx_en=0, write 17 bytes with FIFO_DEPTH=16 -> 17th access PSLVERR=1, tx_full=1; enable tx -> exactly 16 frames emitted.
REQ-035 Read RXDATA when empty -> PRDATA=0, PSLVERR=1; receive 17 bytes unread -> overrun=1, first 16 bytes intact.
REQ-036 Assert PRESETn=0 mid DATA state -> tx=1 next cycle, STATUS=0x0A, BAUD reads 10417.
